// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: FSM state encodings,
// debug command codes and small decode helpers.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_STEP = 2'b10,
      CMD_STOP = 2'b11
   } run_cmd_t;

   // True in the states where the pipeline is allowed to advance.
   function automatic logic is_advancing(input run_state_t state);
      return (state == ST_RUN) || (state == ST_STEP);
   endfunction

   // True when a command handshake completes with the given opcode.
   function automatic logic cmd_hit(input logic       fire,
                                    input logic [1:0] cmd,
                                    input run_cmd_t   code);
      return fire && (cmd == code);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never creates a hazard.
module hazard_detect #(
   parameter int BITS_REGS = 5
) (
   input  logic                 ex_mem_read,
   input  logic [BITS_REGS-1:0] ex_rt,
   input  logic [BITS_REGS-1:0] id_rs,
   input  logic [BITS_REGS-1:0] id_rt,
   output logic                 hazard
);

   logic rt_nonzero_s;
   logic src_match_s;

   // Pure combinational compare of the load target against both ID sources.
   always_comb begin
      rt_nonzero_s = (ex_rt != {BITS_REGS{1'b0}});
      src_match_s  = (ex_rt == id_rs) || (ex_rt == id_rt);
      hazard       = ex_mem_read && rt_nonzero_s && src_match_s;
   end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Debug run/step controller for a 5-stage pipeline: a small command FSM gates
// pipeline advance and arbitrates load-use stalls against taken-branch flushes.
module pipe_run_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int BITS_REGS = 5,
   parameter int BITS_CNT  = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   input  logic [1:0]           i_cmd,
   output logic                 o_cmd_ready,
   input  logic                 i_ex_mem_read,
   input  logic [BITS_REGS-1:0] i_ex_rt,
   input  logic [BITS_REGS-1:0] i_id_rs,
   input  logic [BITS_REGS-1:0] i_id_rt,
   input  logic                 i_branch_taken,
   input  logic                 i_wb_halt,
   output logic                 o_step,
   output logic                 o_pc_write,
   output logic                 o_ifid_write,
   output logic                 o_flush_ifid,
   output logic                 o_flush_idex,
   output logic [1:0]           o_state,
   output logic                 o_halted,
   output logic [BITS_CNT-1:0]  o_step_count
);

   run_state_t          state_r;
   run_state_t          state_nxt_s;
   logic                cmd_fire_s;
   logic                hazard_s;
   logic [BITS_CNT-1:0] step_count_r;

   hazard_detect #(
      .BITS_REGS (BITS_REGS)
   ) u_hazard_detect (
      .ex_mem_read (i_ex_mem_read),
      .ex_rt       (i_ex_rt),
      .id_rs       (i_id_rs),
      .id_rt       (i_id_rt),
      .hazard      (hazard_s)
   );

   // State register; reset is asynchronous so a mid-run abort takes effect at once.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; a halt reaching WB beats any same-cycle command.
   always_comb begin
      cmd_fire_s  = i_cmd_valid && o_cmd_ready;
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_hit(cmd_fire_s, i_cmd, CMD_RUN)) begin
               state_nxt_s = ST_RUN;
            end else if (cmd_hit(cmd_fire_s, i_cmd, CMD_STEP)) begin
               state_nxt_s = ST_STEP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_wb_halt) begin
               state_nxt_s = ST_HALTED;
            end else if (cmd_hit(cmd_fire_s, i_cmd, CMD_STOP)) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_STEP: begin
            if (i_wb_halt) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HALTED: begin
            state_nxt_s = ST_HALTED;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode; the branch flush takes priority because the stalled
   // instruction is on the wrong path anyway.
   always_comb begin
      o_cmd_ready  = (state_r != ST_STEP);
      o_state      = state_r;
      o_halted     = (state_r == ST_HALTED);
      o_step       = is_advancing(state_r) && !i_wb_halt;
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_flush_ifid = 1'b0;
      o_flush_idex = 1'b0;
      if (!o_step) begin
         o_pc_write   = 1'b0;
         o_ifid_write = 1'b0;
         o_flush_ifid = 1'b0;
         o_flush_idex = 1'b0;
      end else if (i_branch_taken) begin
         o_pc_write   = 1'b1;
         o_ifid_write = 1'b1;
         o_flush_ifid = 1'b1;
         o_flush_idex = 1'b1;
      end else if (hazard_s) begin
         o_pc_write   = 1'b0;
         o_ifid_write = 1'b0;
         o_flush_ifid = 1'b0;
         o_flush_idex = 1'b1;
      end else begin
         o_pc_write   = 1'b1;
         o_ifid_write = 1'b1;
         o_flush_ifid = 1'b0;
         o_flush_idex = 1'b0;
      end
   end

   // Advanced-cycle counter, wraps naturally at the counter width.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         step_count_r <= {BITS_CNT{1'b0}};
      end else if (o_step) begin
         step_count_r <= step_count_r + {{(BITS_CNT-1){1'b0}}, 1'b1};
      end else begin
         step_count_r <= step_count_r;
      end
   end

   assign o_step_count = step_count_r;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed self-checking bench for pipe_run_ctrl, plus a narrow-counter
// instance used to exercise counter wrap-around.
module tb_pipe_run_ctrl;

   logic        i_clk;
   logic        i_reset;
   logic        i_cmd_valid;
   logic [1:0]  i_cmd;
   logic        o_cmd_ready;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rt;
   logic [4:0]  i_id_rs;
   logic [4:0]  i_id_rt;
   logic        i_branch_taken;
   logic        i_wb_halt;
   logic        o_step;
   logic        o_pc_write;
   logic        o_ifid_write;
   logic        o_flush_ifid;
   logic        o_flush_idex;
   logic [1:0]  o_state;
   logic        o_halted;
   logic [31:0] o_step_count;

   logic        w_cmd_valid;
   logic [1:0]  w_cmd;
   logic        w_cmd_ready;
   logic        w_zero;
   logic [4:0]  w_reg_zero;
   logic        w_step;
   logic        w_pc_write;
   logic        w_ifid_write;
   logic        w_flush_ifid;
   logic        w_flush_idex;
   logic [1:0]  w_state;
   logic        w_halted;
   logic [3:0]  w_step_count;

   int tests_run;
   int tests_failed;

   pipe_run_ctrl #(.BITS_REGS(5), .BITS_CNT(32)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_cmd_valid    (i_cmd_valid),
      .i_cmd          (i_cmd),
      .o_cmd_ready    (o_cmd_ready),
      .i_ex_mem_read  (i_ex_mem_read),
      .i_ex_rt        (i_ex_rt),
      .i_id_rs        (i_id_rs),
      .i_id_rt        (i_id_rt),
      .i_branch_taken (i_branch_taken),
      .i_wb_halt      (i_wb_halt),
      .o_step         (o_step),
      .o_pc_write     (o_pc_write),
      .o_ifid_write   (o_ifid_write),
      .o_flush_ifid   (o_flush_ifid),
      .o_flush_idex   (o_flush_idex),
      .o_state        (o_state),
      .o_halted       (o_halted),
      .o_step_count   (o_step_count)
   );

   pipe_run_ctrl #(.BITS_REGS(5), .BITS_CNT(4)) dut_wrap (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_cmd_valid    (w_cmd_valid),
      .i_cmd          (w_cmd),
      .o_cmd_ready    (w_cmd_ready),
      .i_ex_mem_read  (w_zero),
      .i_ex_rt        (w_reg_zero),
      .i_id_rs        (w_reg_zero),
      .i_id_rt        (w_reg_zero),
      .i_branch_taken (w_zero),
      .i_wb_halt      (w_zero),
      .o_step         (w_step),
      .o_pc_write     (w_pc_write),
      .o_ifid_write   (w_ifid_write),
      .o_flush_ifid   (w_flush_ifid),
      .o_flush_idex   (w_flush_idex),
      .o_state        (w_state),
      .o_halted       (w_halted),
      .o_step_count   (w_step_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (got !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_cmd(input logic valid, input logic [1:0] cmd);
      i_cmd_valid = valid;
      i_cmd       = cmd;
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      i_reset        = 1'b0;
      i_cmd_valid    = 1'b0;
      i_cmd          = 2'b00;
      i_ex_mem_read  = 1'b0;
      i_ex_rt        = 5'd0;
      i_id_rs        = 5'd0;
      i_id_rt        = 5'd0;
      i_branch_taken = 1'b0;
      i_wb_halt      = 1'b0;
      w_cmd_valid    = 1'b0;
      w_cmd          = 2'b00;
      w_zero         = 1'b0;
      w_reg_zero     = 5'd0;

      // reset values
      #12;
      check_val("rst_state", 32'(o_state), 32'd0);
      check_val("rst_count", o_step_count, 32'd0);
      check_val("rst_step", 32'(o_step), 32'd0);
      check_val("rst_ready", 32'(o_cmd_ready), 32'd1);
      check_val("rst_halted", 32'(o_halted), 32'd0);
      check_val("rst_pcw", 32'(o_pc_write), 32'd0);
      tick();
      i_reset = 1'b1;

      // single STEP
      set_cmd(1'b1, 2'b10);
      #1;
      check_val("step_pre_idle", 32'(o_step), 32'd0);
      tick();
      set_cmd(1'b0, 2'b00);
      check_val("step_state", 32'(o_state), 32'd2);
      check_val("step_high", 32'(o_step), 32'd1);
      check_val("step_ready", 32'(o_cmd_ready), 32'd0);
      check_val("step_pcw", 32'(o_pc_write), 32'd1);
      tick();
      check_val("step_back_idle", 32'(o_state), 32'd0);
      check_val("step_low", 32'(o_step), 32'd0);
      check_val("step_count", o_step_count, 32'd1);

      // RUN for 10 cycles, then STOP (the STOP cycle also advances)
      set_cmd(1'b1, 2'b01);
      tick();
      set_cmd(1'b0, 2'b00);
      check_val("run_state", 32'(o_state), 32'd1);
      check_val("run_count0", o_step_count, 32'd1);
      for (int i = 0; i < 10; i++) tick();
      check_val("run_count10", o_step_count, 32'd11);
      set_cmd(1'b1, 2'b11);
      #1;
      check_val("stop_cycle_step", 32'(o_step), 32'd1);
      tick();
      set_cmd(1'b0, 2'b00);
      check_val("stop_state", 32'(o_state), 32'd0);
      check_val("stop_count", o_step_count, 32'd12);
      tick();
      check_val("stop_no_more", o_step_count, 32'd12);

      // load-use hazard and branch priority, all combinational in RUN
      set_cmd(1'b1, 2'b01);
      tick();
      set_cmd(1'b0, 2'b00);
      i_ex_mem_read = 1'b1;
      i_ex_rt = 5'd5;
      i_id_rs = 5'd5;
      i_id_rt = 5'd7;
      #1;
      check_val("haz_pcw", 32'(o_pc_write), 32'd0);
      check_val("haz_ifidw", 32'(o_ifid_write), 32'd0);
      check_val("haz_fl_idex", 32'(o_flush_idex), 32'd1);
      check_val("haz_fl_ifid", 32'(o_flush_ifid), 32'd0);
      check_val("haz_step", 32'(o_step), 32'd1);
      i_ex_rt = 5'd7;
      i_id_rs = 5'd3;
      #1;
      check_val("haz_rt_pcw", 32'(o_pc_write), 32'd0);
      i_ex_rt = 5'd0;
      i_id_rs = 5'd0;
      i_id_rt = 5'd0;
      #1;
      check_val("r0_pcw", 32'(o_pc_write), 32'd1);
      check_val("r0_fl_idex", 32'(o_flush_idex), 32'd0);
      i_ex_rt = 5'd9;
      i_id_rs = 5'd9;
      i_branch_taken = 1'b1;
      #1;
      check_val("br_fl_ifid", 32'(o_flush_ifid), 32'd1);
      check_val("br_fl_idex", 32'(o_flush_idex), 32'd1);
      check_val("br_pcw", 32'(o_pc_write), 32'd1);
      check_val("br_ifidw", 32'(o_ifid_write), 32'd1);

      // halt with simultaneous STOP; branch still asserted must not flush
      i_wb_halt = 1'b1;
      set_cmd(1'b1, 2'b11);
      #1;
      check_val("halt_step", 32'(o_step), 32'd0);
      check_val("halt_fl_ifid", 32'(o_flush_ifid), 32'd0);
      check_val("halt_pcw", 32'(o_pc_write), 32'd0);
      tick();
      i_wb_halt = 1'b0;
      i_branch_taken = 1'b0;
      i_ex_mem_read = 1'b0;
      set_cmd(1'b1, 2'b01);
      check_val("halt_state", 32'(o_state), 32'd3);
      check_val("halt_flag", 32'(o_halted), 32'd1);
      check_val("halt_count", o_step_count, 32'd12);
      check_val("halt_ready", 32'(o_cmd_ready), 32'd1);
      tick();
      set_cmd(1'b0, 2'b00);
      check_val("halt_run_ign", 32'(o_state), 32'd3);
      check_val("halt_run_step", 32'(o_step), 32'd0);

      // asynchronous reset mid-RUN, no clock edge in between
      i_reset = 1'b0;
      #2;
      check_val("arst_state", 32'(o_state), 32'd0);
      tick();
      i_reset = 1'b1;
      set_cmd(1'b1, 2'b01);
      tick();
      set_cmd(1'b0, 2'b00);
      tick();
      check_val("arst_pre_count", o_step_count, 32'd1);
      i_branch_taken = 1'b1;
      i_reset = 1'b0;
      #2;
      check_val("arst_step", 32'(o_step), 32'd0);
      check_val("arst_state2", 32'(o_state), 32'd0);
      check_val("arst_count", o_step_count, 32'd0);
      check_val("arst_ready", 32'(o_cmd_ready), 32'd1);
      check_val("arst_fl_ifid", 32'(o_flush_ifid), 32'd0);
      check_val("arst_pcw", 32'(o_pc_write), 32'd0);
      i_branch_taken = 1'b0;
      tick();
      i_reset = 1'b1;
      tick();
      check_val("rel_state", 32'(o_state), 32'd0);
      check_val("rel_step", 32'(o_step), 32'd0);
      check_val("rel_count", o_step_count, 32'd0);

      // counter wrap on the 4-bit instance
      w_cmd_valid = 1'b1;
      w_cmd = 2'b01;
      tick();
      w_cmd_valid = 1'b0;
      w_cmd = 2'b00;
      for (int i = 0; i < 15; i++) tick();
      check_val("wrap_max", 32'(w_step_count), 32'hF);
      tick();
      check_val("wrap_zero", 32'(w_step_count), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
